// File: rtl/bus_arbiter_rr.sv
// bus_arbiter_rr: round-robin arbiter that serializes the winner's (ADDRW+8)-bit word LSB-byte-first onto a byte bus.
// Latency: grant and first byte appear 1 cycle after req is sampled in IDLE; NBYTES+2 cycles per transaction at full rate.
// Backpressure: bus_ready low freezes data_out/byte_cnt/valid_out; with BUS_ARB_TIMEOUT_EN a TIMEOUT-cycle stall aborts.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   req[NUM_CH]       level request per channel
//   data_in           flattened words, channel i at [i*(ADDRW+8) +: ADDRW+8]
//   bus_ready         downstream accepts data_out this cycle
//   data_out, valid_out   current byte and its valid
//   grant[NUM_CH]     one-hot, held for the whole transaction
//   done              one-cycle pulse after the last byte is accepted
//   curr_ch           granted / last-granted channel index
//   byte_cnt          index of the byte being presented
//   err_timeout       one-cycle abort pulse (constant 0 unless BUS_ARB_TIMEOUT_EN)
//
// Optional macro: BUS_ARB_TIMEOUT_EN enables the stall watchdog.
module bus_arbiter_rr #(
  parameter int ADDRW   = 24,
  parameter int NUM_CH  = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_CH-1:0]                 req,
  input  logic [NUM_CH*(ADDRW+8)-1:0]       data_in,
  input  logic                              bus_ready,
  output logic [7:0]                        data_out,
  output logic                              valid_out,
  output logic [NUM_CH-1:0]                 grant,
  output logic                              done,
  output logic [$clog2(NUM_CH)-1:0]         curr_ch,
  output logic [$clog2((ADDRW+8)/8)-1:0]    byte_cnt,
  output logic                              err_timeout
);

  localparam int W      = ADDRW + 8;
  localparam int NBYTES = W / 8;
  localparam int CHW    = $clog2(NUM_CH);
  localparam int BCW    = $clog2(NBYTES);

  // Elaboration-time parameter sanity checks.
  if ((ADDRW % 8) != 0 || ADDRW < 8) begin : g_bad_addrw
    $error("bus_arbiter_rr: ADDRW must be a non-zero multiple of 8");
  end
  if (NUM_CH < 2 || NUM_CH > 8) begin : g_bad_num_ch
    $error("bus_arbiter_rr: NUM_CH must be in 2..8");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("bus_arbiter_rr: TIMEOUT must be at least 1");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_COOL = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t          r_state;
  logic [CHW-1:0]  r_rr_ptr;
  logic [NUM_CH-1:0] r_grant;
  logic            r_valid;
  logic            r_done;
  logic [CHW-1:0]  r_curr_ch;
  logic [BCW-1:0]  r_byte_cnt;
  logic [W-1:0]    r_shift;

  state_t          w_state_nxt;
  logic [CHW-1:0]  w_rr_ptr_nxt;
  logic [NUM_CH-1:0] w_grant_nxt;
  logic            w_valid_nxt;
  logic            w_done_nxt;
  logic [CHW-1:0]  w_curr_ch_nxt;
  logic [BCW-1:0]  w_byte_cnt_nxt;
  logic [W-1:0]    w_shift_nxt;

`ifdef BUS_ARB_TIMEOUT_EN
  localparam int SW = $clog2(TIMEOUT + 1);
  logic [SW-1:0]   r_stall;
  logic            r_err;
  logic [SW-1:0]   w_stall_nxt;
  logic            w_err_nxt;
`endif

  // ---------------------------------------------------------------------------
  // Unpack the flattened transaction words so the winner can be indexed directly.
  // ---------------------------------------------------------------------------
  logic [W-1:0] w_words [NUM_CH];

  for (genvar g = 0; g < NUM_CH; g++) begin : g_unpack
    assign w_words[g] = data_in[g*W +: W];
  end

  // ---------------------------------------------------------------------------
  // Round-robin search: first set request starting at r_rr_ptr, wrapping
  // modulo NUM_CH (which need not be a power of two).
  // ---------------------------------------------------------------------------
  logic           w_found;
  logic [CHW-1:0] w_win;
  logic [CHW:0]   w_idx;

  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      w_idx = {1'b0, r_rr_ptr} + (CHW+1)'(k);
      if (w_idx >= (CHW+1)'(NUM_CH)) begin
        w_idx = w_idx - (CHW+1)'(NUM_CH);
      end
      if (!w_found && req[w_idx[CHW-1:0]]) begin
        w_found = 1'b1;
        w_win   = w_idx[CHW-1:0];
      end
    end
  end

  // Pointer for the next arbitration: one past the channel just served.
  logic [CHW-1:0] w_rr_adv;
  assign w_rr_adv = (r_curr_ch == CHW'(NUM_CH - 1)) ? '0 : r_curr_ch + 1'b1;

  logic w_last;
  assign w_last = (r_byte_cnt == BCW'(NBYTES - 1));

  // ---------------------------------------------------------------------------
  // Next-state / next-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt    = r_state;
    w_rr_ptr_nxt   = r_rr_ptr;
    w_grant_nxt    = r_grant;
    w_valid_nxt    = r_valid;
    w_done_nxt     = 1'b0;
    w_curr_ch_nxt  = r_curr_ch;
    w_byte_cnt_nxt = r_byte_cnt;
    w_shift_nxt    = r_shift;
`ifdef BUS_ARB_TIMEOUT_EN
    w_stall_nxt    = r_stall;
    w_err_nxt      = 1'b0;
`endif

    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_state_nxt    = ST_SEND;
          w_grant_nxt    = NUM_CH'(1) << w_win;
          w_curr_ch_nxt  = w_win;
          w_shift_nxt    = w_words[w_win];
          w_byte_cnt_nxt = '0;
          w_valid_nxt    = 1'b1;
`ifdef BUS_ARB_TIMEOUT_EN
          w_stall_nxt    = '0;
`endif
        end
      end

      ST_SEND: begin
        if (bus_ready) begin
`ifdef BUS_ARB_TIMEOUT_EN
          w_stall_nxt = '0;
`endif
          if (w_last) begin
            // Last byte accepted: leave the shift register cleared so
            // data_out idles at zero between transactions.
            w_state_nxt  = ST_COOL;
            w_grant_nxt  = '0;
            w_valid_nxt  = 1'b0;
            w_done_nxt   = 1'b1;
            w_shift_nxt  = '0;
            w_rr_ptr_nxt = w_rr_adv;
          end else begin
            w_shift_nxt    = r_shift >> 8;
            w_byte_cnt_nxt = r_byte_cnt + 1'b1;
          end
        end
`ifdef BUS_ARB_TIMEOUT_EN
        else if (r_stall == SW'(TIMEOUT - 1)) begin
          // This is the TIMEOUT-th consecutive stalled cycle: abort. The
          // COOL cycle then carries err_timeout instead of done.
          w_state_nxt  = ST_COOL;
          w_grant_nxt  = '0;
          w_valid_nxt  = 1'b0;
          w_err_nxt    = 1'b1;
          w_shift_nxt  = '0;
          w_stall_nxt  = '0;
          w_rr_ptr_nxt = w_rr_adv;
        end else begin
          w_stall_nxt = r_stall + 1'b1;
        end
`endif
      end

      ST_COOL: begin
        // Requests are deliberately not sampled here; a requester that has
        // not dropped req by now simply re-arbitrates from IDLE.
        w_state_nxt = ST_IDLE;
      end

      default: begin
        w_state_nxt = ST_IDLE;
        w_grant_nxt = '0;
        w_valid_nxt = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_rr_ptr   <= '0;
      r_grant    <= '0;
      r_valid    <= 1'b0;
      r_done     <= 1'b0;
      r_curr_ch  <= '0;
      r_byte_cnt <= '0;
      r_shift    <= '0;
`ifdef BUS_ARB_TIMEOUT_EN
      r_stall    <= '0;
      r_err      <= 1'b0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_rr_ptr   <= w_rr_ptr_nxt;
      r_grant    <= w_grant_nxt;
      r_valid    <= w_valid_nxt;
      r_done     <= w_done_nxt;
      r_curr_ch  <= w_curr_ch_nxt;
      r_byte_cnt <= w_byte_cnt_nxt;
      r_shift    <= w_shift_nxt;
`ifdef BUS_ARB_TIMEOUT_EN
      r_stall    <= w_stall_nxt;
      r_err      <= w_err_nxt;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign data_out  = r_shift[7:0];
  assign valid_out = r_valid;
  assign grant     = r_grant;
  assign done      = r_done;
  assign curr_ch   = r_curr_ch;
  assign byte_cnt  = r_byte_cnt;

`ifdef BUS_ARB_TIMEOUT_EN
  assign err_timeout = r_err;
`else
  assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// tb_bus_arbiter_rr: directed self-checking bench for bus_arbiter_rr (NUM_CH=4, ADDRW=24, TIMEOUT=8).
// Inputs change and outputs are sampled on the falling clock edge.
// Ends with a single summary line.
module tb_bus_arbiter_rr;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   req;
  logic [127:0] data_in;
  logic         bus_ready;
  logic [7:0]   data_out;
  logic         valid_out;
  logic [3:0]   grant;
  logic         done;
  logic [1:0]   curr_ch;
  logic [1:0]   byte_cnt;
  logic         err_timeout;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  bus_arbiter_rr #(
    .ADDRW   (24),
    .NUM_CH  (4),
    .TIMEOUT (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .data_in     (data_in),
    .bus_ready   (bus_ready),
    .data_out    (data_out),
    .valid_out   (valid_out),
    .grant       (grant),
    .done        (done),
    .curr_ch     (curr_ch),
    .byte_cnt    (byte_cnt),
    .err_timeout (err_timeout)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_word(input int ch, input logic [31:0] w);
    data_in[ch*32 +: 32] = w;
  endtask

  // Called at the negedge where byte 0 is presented; walks all four bytes
  // (bus_ready assumed high) and then checks the COOL cycle and return to IDLE.
  task automatic send_bytes(input string tag, input logic [31:0] word);
    for (int b = 0; b < 4; b++) begin
      chk({tag, "_data"}, data_out, word[8*b +: 8]);
      chk({tag, "_cnt"},  byte_cnt, b);
      chk({tag, "_vld"},  valid_out, 1'b1);
      tick();
    end
    chk({tag, "_done"},      done, 1'b1);
    chk({tag, "_cool_gnt"},  grant, 4'b0000);
    chk({tag, "_cool_vld"},  valid_out, 1'b0);
    tick();
    chk({tag, "_done_clr"},  done, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cnt;
    logic [3:0] exp_g;

    rst_n     = 1'b0;
    req       = 4'b0000;
    bus_ready = 1'b1;
    data_in   = '0;
    set_word(0, 32'h11223344);
    set_word(1, 32'h55667788);
    set_word(2, 32'hA1B2C3D4);
    set_word(3, 32'h0A0B0C0D);

    // ---- Reset values ----
    tick(); tick();
    chk("rst_grant", grant, 4'b0000);
    chk("rst_valid", valid_out, 1'b0);
    chk("rst_done",  done, 1'b0);
    chk("rst_data",  data_out, 8'h00);
    chk("rst_ch",    curr_ch, 2'd0);
    chk("rst_cnt",   byte_cnt, 2'd0);
    chk("rst_err",   err_timeout, 1'b0);
    rst_n = 1'b1;

    // ---- No request: stays idle ----
    tick(); tick();
    chk("idle_grant", grant, 4'b0000);
    chk("idle_valid", valid_out, 1'b0);

    // ---- Single request on ch2; req dropped during SEND is ignored ----
    req = 4'b0100;
    tick();
    chk("t1_grant", grant, 4'b0100);
    chk("t1_ch",    curr_ch, 2'd2);
    req = 4'b0000;
    send_bytes("t1", 32'hA1B2C3D4);
    chk("t1_ch_hold", curr_ch, 2'd2);

    // ---- data_in changes after grant: in-flight word unaffected ----
    req = 4'b0100;
    tick();
    chk("t2_grant", grant, 4'b0100);
    req = 4'b0000;
    set_word(2, 32'hFFFFFFFF);
    send_bytes("t2", 32'hA1B2C3D4);
    set_word(2, 32'hA1B2C3D4);

    // ---- Backpressure: bus_ready low for 3 cycles while byte 1 is shown ----
    req = 4'b0100;
    tick();
    chk("t3_grant", grant, 4'b0100);
    req = 4'b0000;
    chk("t3_b0", data_out, 8'hD4);
    tick();
    chk("t3_b1", data_out, 8'hC3);
    bus_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      tick();
      chk("t3_hold_data", data_out, 8'hC3);
      chk("t3_hold_cnt",  byte_cnt, 2'd1);
      chk("t3_hold_vld",  valid_out, 1'b1);
    end
    bus_ready = 1'b1;
    tick();
    chk("t3_b2",     data_out, 8'hB2);
    chk("t3_b2_cnt", byte_cnt, 2'd2);
    tick();
    chk("t3_b3",     data_out, 8'hA1);
    chk("t3_b3_cnt", byte_cnt, 2'd3);
    tick();
    chk("t3_done",   done, 1'b1);
    tick();
    chk("t3_done_clr", done, 1'b0);

    // ---- Reset during byte 2; rr_ptr (now 3) must return to 0 ----
    req = 4'b0100;
    tick();
    chk("t4_grant", grant, 4'b0100);
    req = 4'b0000;
    tick();
    tick();
    chk("t4_cnt2", byte_cnt, 2'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("t4_rst_grant", grant, 4'b0000);
    chk("t4_rst_valid", valid_out, 1'b0);
    chk("t4_rst_data",  data_out, 8'h00);
    chk("t4_rst_cnt",   byte_cnt, 2'd0);
    chk("t4_rst_ch",    curr_ch, 2'd0);
    tick();
    rst_n = 1'b1;
    // ch3 also requests: with rr_ptr=0 ch0 must still win.
    req = 4'b1001;
    tick();
    chk("t4_grant0", grant, 4'b0001);
    req = 4'b0000;
    send_bytes("t4", 32'h11223344);

    // ---- Round-robin from a fresh reset: ch0, ch1, ch2, ch3, ch0 ----
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    req = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      exp_g = 4'(1 << (t % 4));
      cnt = 0;
      while (grant == 4'b0000 && cnt < 10) begin
        tick();
        cnt++;
      end
      chk("rr_grant", grant, exp_g);
      cnt = 0;
      while (done !== 1'b1 && cnt < 10) begin
        tick();
        cnt++;
      end
      chk("rr_done", done, 1'b1);
      req = 4'b1111 & ~exp_g;
      tick();
      req = 4'b1111;
    end
    req = 4'b0000;
    tick(); tick(); tick();

`ifdef BUS_ARB_TIMEOUT_EN
    // ---- Stall watchdog: bus_ready held low aborts after 8 stalled cycles ----
    bus_ready = 1'b0;
    req = 4'b0010;
    tick();
    chk("to_grant", grant, 4'b0010);
    req = 4'b0000;
    for (int s = 0; s < 7; s++) begin
      tick();
      chk("to_wait_err", err_timeout, 1'b0);
      chk("to_wait_vld", valid_out, 1'b1);
    end
    tick();
    chk("to_err",   err_timeout, 1'b1);
    chk("to_done",  done, 1'b0);
    chk("to_grant0", grant, 4'b0000);
    tick();
    chk("to_err_clr", err_timeout, 1'b0);
    bus_ready = 1'b1;
    req = 4'b0100;
    tick();
    chk("to_next_grant", grant, 4'b0100);
    req = 4'b0000;
    send_bytes("to_next", 32'hA1B2C3D4);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
